// File: rtl/adc_capture_sequencer_if.sv
// Purpose: control, ADC handshake and status bundle between the PS-side controller and the capture sequencer.
// Latency: none (wires only).
// Backpressure: i_DMA_Ready gates frame start; i_ADC_Done / o_ADC_Work form a four-phase handshake.
interface adc_capture_sequencer_if #(
  parameter int FRAME_CNT_W = 16,
  parameter int GAP_W       = 16
) ();

  // Control from PS registers
  logic                   i_Start;
  logic                   i_Stop;
  logic [FRAME_CNT_W-1:0] i_Frame_Count;
  logic [GAP_W-1:0]       i_Gap_Cycles;
  logic                   i_DMA_Ready;

  // Handshake with the ADC capture block
  logic                   o_ADC_Work;
  logic                   i_ADC_Done;
  logic                   i_ADC_Last;

  // Status back to PS
  logic                   o_Busy;
  logic [FRAME_CNT_W-1:0] o_Frames_Done;
  logic                   o_Err_Last;
  logic                   o_Err_Timeout;
  logic                   o_Irq;

  // Sequencer side
  modport slave (
    input  i_Start, i_Stop, i_Frame_Count, i_Gap_Cycles, i_DMA_Ready,
    input  i_ADC_Done, i_ADC_Last,
    output o_ADC_Work, o_Busy, o_Frames_Done, o_Err_Last, o_Err_Timeout, o_Irq
  );

  // Controller / capture-block side
  modport master (
    output i_Start, i_Stop, i_Frame_Count, i_Gap_Cycles, i_DMA_Ready,
    output i_ADC_Done, i_ADC_Last,
    input  o_ADC_Work, o_Busy, o_Frames_Done, o_Err_Last, o_Err_Timeout, o_Irq
  );

endinterface

// File: rtl/adc_capture_sequencer.sv
// Purpose: runs N capture frames (0 = until stop) on the ADC block with a programmable inter-frame gap.
// Latency: work rises 1 cycle after start/ARM exit; GAP holds exactly i_Gap_Cycles cycles between frames.
// Backpressure: ARM waits for i_DMA_Ready=1 and a deasserted i_ADC_Done before issuing work.
// Optional: define ADC_SEQ_TIMEOUT_EN to enable the RUN-state watchdog (o_Err_Timeout); otherwise it is tied 0.
module adc_capture_sequencer #(
  parameter int FRAME_CNT_W    = 16,
  parameter int GAP_W          = 16,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic                   i_CMOS_Clk,
  input  logic                   i_Rst_n,
  adc_capture_sequencer_if.slave bus
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ARM     = 3'd1;
  localparam logic [2:0] ST_RUN     = 3'd2;
  localparam logic [2:0] ST_RELEASE = 3'd3;
  localparam logic [2:0] ST_GAP     = 3'd4;
  localparam logic [2:0] ST_FINISH  = 3'd5;
  localparam logic [2:0] ST_ERROR   = 3'd6;

  // Elaboration-time guard: a zero watchdog limit would fire before any frame could run.
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_range
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  logic [2:0]             state_q;
  logic [2:0]             state_d;

  logic [FRAME_CNT_W-1:0] count_q;      // frames requested, 0 = continuous
  logic [GAP_W-1:0]       gap_q;        // gap length latched at start
  logic [GAP_W-1:0]       gap_cnt_q;    // remaining GAP cycles
  logic [FRAME_CNT_W-1:0] frames_q;
  logic [FRAME_CNT_W-1:0] frames_inc;

  logic                   stop_q;       // stop requested while busy
  logic                   seen_last_q;  // last pulse observed in the current frame
  logic                   work_q;
  logic                   err_last_q;
  logic                   irq_q;

  logic                   start_acc;    // start accepted this cycle
  logic                   stop_req;     // stop pending, including this cycle's pulse
  logic                   frame_end;    // RELEASE sees done low: frame retires on this edge
  logic                   last_frame;   // the retiring frame ends the sequence
  logic                   timeout_hit;

  assign start_acc  = (state_q == ST_IDLE) && bus.i_Start;
  assign stop_req   = stop_q || bus.i_Stop;
  assign frame_end  = (state_q == ST_RELEASE) && !bus.i_ADC_Done;
  assign frames_inc = frames_q + FRAME_CNT_W'(1);
  assign last_frame = stop_req || ((count_q != '0) && (frames_inc == count_q));

`ifdef ADC_SEQ_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_cnt_q;
  logic            err_to_q;

  // Watchdog: counts cycles spent in RUN, restarting from 0 on every RUN entry.
  always_ff @(posedge i_CMOS_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      to_cnt_q <= '0;
    end else if (state_q != ST_RUN) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_q + TO_W'(1);
    end
  end

  // Fires on the last allowed RUN cycle if the capture block still has not reported done.
  assign timeout_hit = (state_q == ST_RUN) && !bus.i_ADC_Done &&
                       (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  // Sticky timeout flag, cleared only by an accepted start.
  always_ff @(posedge i_CMOS_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      err_to_q <= 1'b0;
    end else if (start_acc) begin
      err_to_q <= 1'b0;
    end else if (timeout_hit) begin
      err_to_q <= 1'b1;
    end
  end

  assign bus.o_Err_Timeout = err_to_q;
`else
  assign timeout_hit       = 1'b0;
  assign bus.o_Err_Timeout = 1'b0;
`endif

  // Next-state selection for the frame sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_Start) begin
          state_d = ST_ARM;
        end
      end
      ST_ARM: begin
        // A stale done from the previous handshake must clear before new work is issued.
        if (stop_req) begin
          state_d = ST_FINISH;
        end else if (bus.i_DMA_Ready && !bus.i_ADC_Done) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (timeout_hit) begin
          state_d = ST_ERROR;
        end else if (bus.i_ADC_Done) begin
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (!bus.i_ADC_Done) begin
          if (last_frame) begin
            state_d = ST_FINISH;
          end else if (gap_q == '0) begin
            state_d = ST_ARM;
          end else begin
            state_d = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (stop_req) begin
          state_d = ST_FINISH;
        end else if (gap_cnt_q == GAP_W'(1)) begin
          state_d = ST_ARM;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      ST_ERROR:  state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_CMOS_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Sequence configuration is captured once per accepted start and held for the whole run.
  always_ff @(posedge i_CMOS_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      count_q <= '0;
      gap_q   <= '0;
    end else if (start_acc) begin
      count_q <= bus.i_Frame_Count;
      gap_q   <= bus.i_Gap_Cycles;
    end
  end

  // Gap down-counter: loaded when a frame retires into GAP, decremented while in GAP.
  always_ff @(posedge i_CMOS_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      gap_cnt_q <= '0;
    end else if (frame_end) begin
      gap_cnt_q <= gap_q;
    end else if ((state_q == ST_GAP) && (gap_cnt_q != '0)) begin
      gap_cnt_q <= gap_cnt_q - GAP_W'(1);
    end
  end

  // Stop flag: remembers a stop pulse so the in-flight frame can finish first.
  always_ff @(posedge i_CMOS_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      stop_q <= 1'b0;
    end else if (start_acc) begin
      stop_q <= 1'b0;
    end else if ((state_q != ST_IDLE) && bus.i_Stop) begin
      stop_q <= 1'b1;
    end
  end

  // Per-frame last-sample tracker, only meaningful while work is asserted.
  always_ff @(posedge i_CMOS_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      seen_last_q <= 1'b0;
    end else if (start_acc || frame_end) begin
      seen_last_q <= 1'b0;
    end else if ((state_q == ST_RUN) && bus.i_ADC_Last) begin
      seen_last_q <= 1'b1;
    end
  end

  // Work request is high exactly while the sequencer is in RUN.
  always_ff @(posedge i_CMOS_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      work_q <= 1'b0;
    end else begin
      work_q <= (state_d == ST_RUN);
    end
  end

  // Frames-completed counter; wraps freely in continuous mode.
  always_ff @(posedge i_CMOS_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      frames_q <= '0;
    end else if (start_acc) begin
      frames_q <= '0;
    end else if (frame_end) begin
      frames_q <= frames_inc;
    end
  end

  // Sticky missing-last flag; status only, the sequence carries on.
  always_ff @(posedge i_CMOS_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      err_last_q <= 1'b0;
    end else if (start_acc) begin
      err_last_q <= 1'b0;
    end else if (frame_end && !seen_last_q) begin
      err_last_q <= 1'b1;
    end
  end

  // One-cycle interrupt, high for the single FINISH or ERROR cycle.
  always_ff @(posedge i_CMOS_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= (state_d == ST_FINISH) || (state_d == ST_ERROR);
    end
  end

  assign bus.o_ADC_Work    = work_q;
  assign bus.o_Busy        = (state_q != ST_IDLE);
  assign bus.o_Frames_Done = frames_q;
  assign bus.o_Err_Last    = err_last_q;
  assign bus.o_Irq         = irq_q;

endmodule

// File: tb/tb_adc_capture_sequencer.sv
// Bench for adc_capture_sequencer: directed table, hand-written corner sequences and randomized runs
// against a frame-level reference model; a capture-block responder answers each work request.
module tb_adc_capture_sequencer;

  localparam int FW = 16;
  localparam int GW = 16;
  localparam int TO = 500;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  adc_capture_sequencer_if #(.FRAME_CNT_W(FW), .GAP_W(GW)) bus ();

  adc_capture_sequencer #(
    .FRAME_CNT_W   (FW),
    .GAP_W         (GW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_CMOS_Clk(clk),
    .i_Rst_n   (rst_n),
    .bus       (bus)
  );

  // Scenario record: stimulus plus expected end-of-sequence results.
  typedef struct {
    int count;
    int gap;
    int delay;
    int hold;
    int omit;       // bit i set: frame i (0-based) has no last pulse
    int stop_mode;  // 0 none, 1 stop during RUN of frame k, 2 stop during GAP after frame k
    int stop_k;
    int exp_frames;
    int exp_err_last;
  } vec_t;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  // Responder / monitor state (written at negedge by the monitor process)
  int   cyc = 0;
  int   rsp_cnt = 0, hold_left = 0, frame_idx = 0;
  int   cfg_delay = 10, cfg_hold = 0, cfg_gap = 0;
  logic [31:0] cfg_omit = '0;
  logic force_done = 1'b0;
  logic rsp_done = 1'b0;
  logic stale = 1'b0;
  int   rises = 0, irqs = 0, drop_cyc = 0, done_cyc = 0, run_len = 0, last_run = 0;
  bit   have_drop = 0, done_pend = 0;
  logic work_prev = 1'b0;

  assign bus.i_ADC_Done = rsp_done | stale;

  // Monitor then capture-block model, evaluated once per falling edge.
  initial begin
    bus.i_ADC_Last = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.o_ADC_Work && !work_prev) begin
        rises++;
        run_len = 0;
        // done drop -> RELEASE exit edge, gap cycles of GAP, one ARM cycle, then work visible
        if (have_drop) check("gap_to_work", cyc - drop_cyc, cfg_gap + 2);
        have_drop = 0;
      end
      if (bus.o_ADC_Work) run_len++;
      if (!bus.o_ADC_Work && work_prev) begin
        last_run = run_len;
        if (done_pend) check("work_drop_after_done", cyc - done_cyc, 1);
        done_pend = 0;
      end
      if (bus.o_Irq) irqs++;
      work_prev = bus.o_ADC_Work;

      bus.i_ADC_Last = 1'b0;
      if (!rst_n) begin
        rsp_done = 1'b0;
        rsp_cnt  = 0;
      end else if (rsp_done) begin
        if (!bus.o_ADC_Work) begin
          if (hold_left == 0) begin
            rsp_done  = 1'b0;
            drop_cyc  = cyc;
            have_drop = 1;
          end else begin
            hold_left--;
          end
        end
      end else if (bus.o_ADC_Work) begin
        rsp_cnt++;
        if (cfg_delay > 1 && rsp_cnt == cfg_delay - 1 && frame_idx < 32 && !cfg_omit[frame_idx])
          bus.i_ADC_Last = 1'b1;
        if ((cfg_delay > 0 && rsp_cnt >= cfg_delay) || force_done) begin
          rsp_done  = 1'b1;
          rsp_cnt   = 0;
          frame_idx++;
          hold_left = cfg_hold;
          done_cyc  = cyc;
          done_pend = 1;
        end
      end else begin
        rsp_cnt = 0;
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    bus.i_Start = 1'b1;
    tick();
    bus.i_Start = 1'b0;
  endtask

  task automatic pulse_stop();
    bus.i_Stop = 1'b1;
    tick();
    bus.i_Stop = 1'b0;
  endtask

  task automatic setup(input int count, input int gap, input int delay, input int hold, input int omit);
    rises = 0; irqs = 0; have_drop = 0; done_pend = 0; frame_idx = 0;
    force_done = 1'b0; stale = 1'b0;
    cfg_delay = delay; cfg_hold = hold; cfg_gap = gap; cfg_omit = omit;
    bus.i_Frame_Count = FW'(count);
    bus.i_Gap_Cycles  = GW'(gap);
    bus.i_DMA_Ready   = 1'b1;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (bus.o_Busy && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_reached_idle"}, bus.o_Busy, 0);
    tick(2);
  endtask

  // Frame-level reference: how many frames retire and whether any of them lacked a last pulse.
  function automatic int model_frames(input int count, input int stop_mode, input int k);
    if (stop_mode == 0) return count;
    return (count != 0 && k > count) ? count : k;
  endfunction

  function automatic int model_err_last(input int frames, input int omit);
    int m = 0;
    for (int i = 0; i < frames && i < 32; i++) if (omit[i]) m = 1;
    return m;
  endfunction

  task automatic run_seq(input vec_t v, input string tag);
    int n;
    setup(v.count, v.gap, v.delay, v.hold, v.omit);
    pulse_start();
    // configuration changes while busy must not affect the running sequence
    bus.i_Frame_Count = FW'(7);
    bus.i_Gap_Cycles  = GW'(3);
    if (v.stop_mode == 1) begin
      n = 0;
      while (!(rises >= v.stop_k && bus.o_ADC_Work) && n < 20000) begin tick(); n++; end
      tick(2);
      pulse_stop();
    end else if (v.stop_mode == 2) begin
      n = 0;
      while (int'(bus.o_Frames_Done) != v.stop_k && n < 20000) begin tick(); n++; end
      pulse_stop();
    end
    wait_idle(20000, tag);
    check({tag, "_frames_done"}, bus.o_Frames_Done, v.exp_frames);
    check({tag, "_work_pulses"}, rises, v.exp_frames);
    check({tag, "_err_last"}, bus.o_Err_Last, v.exp_err_last);
    check({tag, "_err_timeout"}, bus.o_Err_Timeout, 0);
    check({tag, "_irq_pulses"}, irqs, 1);
  endtask

  vec_t tbl[6];

  initial begin
    int n;
    vec_t rv;
    bus.i_Start = 1'b0; bus.i_Stop = 1'b0; bus.i_DMA_Ready = 1'b0;
    bus.i_Frame_Count = '0; bus.i_Gap_Cycles = '0;

    //        count gap delay hold omit  stop k  frames err_last
    tbl[0] = '{3,   10, 100,  1,   0,    0,   0, 3,     0};
    tbl[1] = '{0,   4,  30,   0,   0,    1,   2, 2,     0};
    tbl[2] = '{3,   2,  12,   2,   2,    0,   0, 3,     1};
    tbl[3] = '{1,   0,  2,    0,   0,    0,   0, 1,     0};
    tbl[4] = '{4,   5,  8,    1,   0,    2,   2, 2,     0};
    tbl[5] = '{2,   0,  9,    3,   1,    1,   2, 2,     1};

    // Reset values, both during and after reset
    tick(3);
    check("rst_work", bus.o_ADC_Work, 0);
    check("rst_busy", bus.o_Busy, 0);
    check("rst_frames", bus.o_Frames_Done, 0);
    check("rst_irq", bus.o_Irq, 0);
    check("rst_err_last", bus.o_Err_Last, 0);
    check("rst_err_timeout", bus.o_Err_Timeout, 0);
    rst_n = 1'b1;
    tick(2);
    check("idle_busy", bus.o_Busy, 0);
    // stop in IDLE is ignored
    pulse_stop();
    check("idle_stop_busy", bus.o_Busy, 0);

    for (int i = 0; i < 6; i++) run_seq(tbl[i], $sformatf("vec%0d", i));

    // DMA not ready for 50 cycles in ARM
    setup(1, 0, 6, 0, 0);
    bus.i_DMA_Ready = 1'b0;
    pulse_start();
    tick(50);
    check("dma_wait_work", rises, 0);
    check("dma_wait_busy", bus.o_Busy, 1);
    bus.i_DMA_Ready = 1'b1;
    check("dma_work_before_ready_edge", bus.o_ADC_Work, 0);
    tick();
    check("dma_work_after_ready", bus.o_ADC_Work, 1);
    wait_idle(2000, "dma");
    check("dma_frames", bus.o_Frames_Done, 1);

    // Stale done in ARM holds off work
    setup(1, 0, 6, 0, 0);
    stale = 1'b1;
    pulse_start();
    tick(10);
    check("stale_work", bus.o_ADC_Work, 0);
    stale = 1'b0;
    tick();
    check("stale_work_after_clear", bus.o_ADC_Work, 1);
    wait_idle(2000, "stale");
    check("stale_frames", bus.o_Frames_Done, 1);

    // Start+stop together in IDLE: start wins; start while busy ignored
    setup(2, 1, 10, 0, 0);
    bus.i_Start = 1'b1; bus.i_Stop = 1'b1;
    tick();
    bus.i_Start = 1'b0; bus.i_Stop = 1'b0;
    tick(5);
    pulse_start();
    wait_idle(2000, "startstop");
    check("startstop_frames", bus.o_Frames_Done, 2);
    check("startstop_pulses", rises, 2);
    check("startstop_irq", irqs, 1);

    // Asynchronous reset in the middle of the second frame
    setup(5, 2, 50, 0, 0);
    pulse_start();
    n = 0;
    while (rises < 2 && n < 2000) begin tick(); n++; end
    tick(10);
    check("prerst_frames", bus.o_Frames_Done, 1);
    check("prerst_work", bus.o_ADC_Work, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_work", bus.o_ADC_Work, 0);
    check("midrst_busy", bus.o_Busy, 0);
    check("midrst_frames", bus.o_Frames_Done, 0);
    check("midrst_irq", bus.o_Irq, 0);
    tick(2);
    rst_n = 1'b1;
    tick(3);
    check("postrst_busy", bus.o_Busy, 0);

    // Capture block never reports done
    setup(1, 0, 0, 0, 0);
    pulse_start();
`ifdef ADC_SEQ_TIMEOUT_EN
    wait_idle(2000, "timeout");
    check("timeout_work_len", last_run, TO);
    check("timeout_flag", bus.o_Err_Timeout, 1);
    check("timeout_irq", irqs, 1);
    check("timeout_frames", bus.o_Frames_Done, 0);
`else
    tick(600);
    check("nowd_work", bus.o_ADC_Work, 1);
    check("nowd_busy", bus.o_Busy, 1);
    check("nowd_err_timeout", bus.o_Err_Timeout, 0);
    force_done = 1'b1;
    wait_idle(2000, "nowd");
    check("nowd_frames", bus.o_Frames_Done, 1);
    check("nowd_err_last", bus.o_Err_Last, 1);
    check("nowd_irq", irqs, 1);
`endif

    // Randomized sequences against the frame-level model
    for (int r = 0; r < 10; r++) begin
      rv.count = $urandom_range(1, 5);
      rv.gap   = $urandom_range(0, 6);
      rv.delay = $urandom_range(8, 25);
      rv.hold  = $urandom_range(0, 3);
      rv.omit  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 31)) : 0;
      rv.stop_mode = $urandom_range(0, 2);
      if (rv.stop_mode == 2 && (rv.count < 2 || rv.gap < 2)) rv.stop_mode = 0;
      rv.stop_k = (rv.stop_mode == 1) ? int'($urandom_range(1, rv.count)) :
                  (rv.stop_mode == 2) ? int'($urandom_range(1, rv.count - 1)) : 0;
      rv.exp_frames   = model_frames(rv.count, rv.stop_mode, rv.stop_k);
      rv.exp_err_last = model_err_last(rv.exp_frames, rv.omit);
      run_seq(rv, $sformatf("rnd%0d", r));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
